// File: rtl/frame_fir_filter_pkg.sv
// Shared types and arithmetic helpers for the frame FIR filter.
// The round/saturate stage works on a 64-bit container so it serves any width.
package frame_fir_filter_pkg;

    typedef enum logic [1:0] {
        FILL,
        COMPUTE,
        DRAIN
    } state_e;

    function automatic int acc_width(input int dw, input int cw, input int nt);
        return dw + cw + $clog2(nt) + 1;
    endfunction

    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int frac,
        input int dw
    );
        logic signed [63:0] r, hi, lo;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/frame_fir_filter_if.sv
// Stream, coefficient-load and status bundle of the frame FIR filter.
// master drives samples and coefficients, slave is the filter.
interface frame_fir_filter_if #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int AW     = 4
);
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     bypass;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;
    logic                     busy;

    modport master (
        output coef_we, coef_addr, coef_data, bypass,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, bypass,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/frame_fir_filter_mac.sv
// Shared signed multiply-accumulate with clear/enable and round/sat output.
// The accumulator is wide enough that a full tap sum cannot overflow.
module fp_mac
    import frame_fir_filter_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int COEF_W   = 18,
    parameter int FRAC_W   = 17,
    parameter int NUM_TAPS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [DATA_W-1:0] y
);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, NUM_TAPS);

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_q;

    assign prod = x * c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        end
    end

    assign y = DATA_W'(round_sat({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                                 FRAC_W, DATA_W));
endmodule

// File: rtl/frame_fir_filter.sv
// Frame-buffered FIR: fill a frame, convolve with one MAC, drain the result.
// Bypass frames skip COMPUTE and drain the stored input directly.
module frame_fir_filter
    import frame_fir_filter_pkg::*;
#(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int FRAC_W    = 17,
    parameter int FRAME_LEN = 64,
    parameter int NUM_TAPS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    frame_fir_filter_if.slave  bus
);
    localparam int NW = $clog2(FRAME_LEN);
    localparam int KW = $clog2(NUM_TAPS + 1);
    localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CW = (NW > KW) ? NW : KW;
    localparam logic [NW-1:0] N_LAST = NW'(FRAME_LEN - 1);
    localparam logic [KW-1:0] K_WB   = KW'(NUM_TAPS);

    state_e state_q, state_d;
    logic   live_q, bypass_q;
    logic [NW-1:0] wr_q, rd_q, n_q;
    logic [KW-1:0] k_q;
    logic [CW-1:0] nx, kx, dx;

    logic signed [DATA_W-1:0] xbuf [FRAME_LEN];
    logic signed [DATA_W-1:0] ybuf [FRAME_LEN];
    logic signed [COEF_W-1:0] coef [NUM_TAPS];

    logic in_fire, out_fire, wb, mac_en;
    logic signed [DATA_W-1:0] x_tap, y_mac;
    logic signed [COEF_W-1:0] c_tap;

    assign bus.in_ready  = live_q && (state_q == FILL);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_last  = bus.out_valid && (rd_q == N_LAST);
    assign bus.busy      = (state_q != FILL);
    assign bus.out_data  = !bus.out_valid ? '0 :
                           bypass_q ? xbuf[rd_q] : ybuf[rd_q];

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign wb       = (state_q == COMPUTE) && (k_q == K_WB);
    assign mac_en   = (state_q == COMPUTE) && !wb;

    // Taps reaching before sample 0 read as zero: each frame has no history.
    always_comb begin
        nx    = CW'(n_q);
        kx    = CW'(k_q);
        dx    = nx - kx;
        x_tap = '0;
        c_tap = '0;
        if (nx >= kx) x_tap = xbuf[dx[NW-1:0]];
        if (k_q != K_WB) c_tap = coef[k_q[AW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:
                if (in_fire && wr_q == N_LAST)
                    state_d = bypass_q ? DRAIN : COMPUTE;
            COMPUTE:
                if (wb && n_q == N_LAST) state_d = DRAIN;
            DRAIN:
                if (out_fire && rd_q == N_LAST) state_d = FILL;
            default:
                state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            live_q   <= 1'b0;
            bypass_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            n_q      <= '0;
            k_q      <= '0;
            for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (in_fire) begin
                wr_q <= (wr_q == N_LAST) ? '0 : wr_q + 1'b1;
                if (wr_q == '0) bypass_q <= bus.bypass;
            end
            if (state_q == COMPUTE) begin
                if (wb) begin
                    k_q <= '0;
                    n_q <= (n_q == N_LAST) ? '0 : n_q + 1'b1;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
            if (out_fire) rd_q <= (rd_q == N_LAST) ? '0 : rd_q + 1'b1;
            // Coefficients only change between frames, never under a live frame.
            if (bus.coef_we && state_q == FILL && wr_q == '0)
                coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) xbuf[wr_q] <= bus.in_data;
        if (wb) ybuf[n_q] <= y_mac;
    end

    fp_mac #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .FRAC_W  (FRAC_W),
        .NUM_TAPS(NUM_TAPS)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(wb),
        .en (mac_en),
        .x  (x_tap),
        .c  (c_tap),
        .y  (y_mac)
    );
endmodule
